// File: rtl/mer_meas_ctrl_pkg.sv
// Shared types and constants for the MER measurement-window scheduler.
package mer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        ACCUM,
        LATCH
    } state_e;

    localparam int DW = 18;

    localparam logic [DW-1:0]        ERR_PWR_MAX = 18'h3FFFF;
    localparam logic signed [DW-1:0] REF_MAX     = 18'sh1FFFF;

endpackage

// File: rtl/mer_meas_ctrl_if.sv
// Result readout bus of the MER scheduler: averaged results plus valid/ack handshake.
interface mer_meas_ctrl_if #(
    parameter int LOG2_WIN = 10
);
    import mer_pkg::*;

    logic signed [DW-1:0] ref_level;
    logic [DW-1:0]        err_pwr;
    logic [LOG2_WIN:0]    err_count;
    logic                 result_valid;
    logic                 result_ack;
    logic                 overrun;
    logic                 mer_alarm;

    modport master (
        output ref_level, err_pwr, err_count, result_valid, overrun, mer_alarm,
        input  result_ack
    );

    modport slave (
        input  ref_level, err_pwr, err_count, result_valid, overrun, mer_alarm,
        output result_ack
    );

endinterface

// File: rtl/mer_meas_ctrl_accum.sv
// Window accumulators for squared error, |dec_var| and symbol errors, with
// window-mean shift and saturation applied to the values handed to the latch.
module mer_accum
    import mer_pkg::*;
#(
    parameter int LOG2_WIN = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 en,
    input  logic signed [DW-1:0] error,
    input  logic signed [DW-1:0] dec_var,
    input  logic                 sym_error,
    output logic [DW-1:0]        err_pwr_sat,
    output logic signed [DW-1:0] ref_level_sat,
    output logic [LOG2_WIN:0]    err_cnt
);

    localparam int AW = 19 + LOG2_WIN;
    localparam logic [AW-1:0] PWR_LIM = AW'(ERR_PWR_MAX);
    localparam logic [AW-1:0] REF_LIM = AW'($unsigned(REF_MAX));

    logic [AW-1:0]         err_acc_q, err_acc_d;
    logic [AW-1:0]         abs_acc_q, abs_acc_d;
    logic [LOG2_WIN:0]     err_cnt_q, err_cnt_d;
    logic signed [2*DW-1:0] sq_s;
    logic signed [DW:0]    dec_ext;
    logic [DW:0]           abs_dec;

    function automatic logic [DW-1:0] sat_mean(input logic [AW-1:0] acc,
                                               input logic [AW-1:0] lim);
        logic [AW-1:0] avg;
        avg = acc >> LOG2_WIN;
        if (avg > lim) begin
            avg = lim;
        end
        return DW'(avg);
    endfunction

    // Square is non-negative, so only bits [35:17] carry weight after scaling.
    always_comb begin
        sq_s    = (2*DW)'(error) * (2*DW)'(error);
        dec_ext = {dec_var[DW-1], dec_var};
        abs_dec = (dec_ext < 0) ? $unsigned(-dec_ext) : $unsigned(dec_ext);

        err_acc_d = err_acc_q;
        abs_acc_d = abs_acc_q;
        err_cnt_d = err_cnt_q;
        if (clear) begin
            err_acc_d = '0;
            abs_acc_d = '0;
            err_cnt_d = '0;
        end else if (en) begin
            err_acc_d = err_acc_q + AW'($unsigned(sq_s >> (DW-1)));
            abs_acc_d = abs_acc_q + AW'(abs_dec);
            err_cnt_d = err_cnt_q + (LOG2_WIN+1)'(sym_error);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_acc_q <= '0;
            abs_acc_q <= '0;
            err_cnt_q <= '0;
        end else begin
            err_acc_q <= err_acc_d;
            abs_acc_q <= abs_acc_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_pwr_sat   = sat_mean(err_acc_q, PWR_LIM);
    assign ref_level_sat = $signed(sat_mean(abs_acc_q, REF_LIM));
    assign err_cnt       = err_cnt_q;

endmodule

// File: rtl/mer_meas_ctrl.sv
// MER measurement-window scheduler: clear, settle, accumulate, latch, valid/ack.
// Optional build macro MER_ALARM_EN adds the registered err_pwr threshold alarm.
module mer_meas_ctrl
    import mer_pkg::*;
#(
    parameter int                   LOG2_WIN    = 10,
    parameter int                   SETTLE_SYMS = 3,
    parameter logic signed [DW-1:0] REF_INIT    = 18'sd32768,
    parameter logic [DW-1:0]        MER_THRESH  = 18'd4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sym_clk_en,
    input  logic                 start,
    input  logic                 cont_mode,
    input  logic signed [DW-1:0] error,
    input  logic signed [DW-1:0] dec_var,
    input  logic                 sym_error,
    output logic                 clear_accum,
    output logic                 busy,
    mer_meas_ctrl_if.master      res
);

    localparam int CW_SETTLE = $clog2(SETTLE_SYMS + 1);
    localparam int CW        = ((LOG2_WIN > CW_SETTLE) ? LOG2_WIN : CW_SETTLE) + 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_SYMS - 1);
    localparam logic [CW-1:0] WIN_LAST    = CW'((1 << LOG2_WIN) - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 clear_q, clear_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic [DW-1:0]        err_pwr_q, err_pwr_d;
    logic signed [DW-1:0] ref_level_q, ref_level_d;
    logic [LOG2_WIN:0]    err_count_q, err_count_d;
    logic                 latch;

    logic [DW-1:0]        pwr_new;
    logic signed [DW-1:0] ref_new;
    logic [LOG2_WIN:0]    cnt_new;

    mer_accum #(.LOG2_WIN(LOG2_WIN)) u_accum (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear_q),
        .en            (sym_clk_en && (state_q == ACCUM)),
        .error         (error),
        .dec_var       (dec_var),
        .sym_error     (sym_error),
        .err_pwr_sat   (pwr_new),
        .ref_level_sat (ref_new),
        .err_cnt       (cnt_new)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clear_d     = 1'b0;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        err_pwr_d   = err_pwr_q;
        ref_level_d = ref_level_q;
        err_count_d = err_count_q;
        latch       = 1'b0;

        if (valid_q && res.result_ack) begin
            valid_d = 1'b0;
        end

        if (sym_clk_en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = CLEAR;
                        clear_d = 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_d   = '0;
                    state_d = (SETTLE_SYMS == 0) ? ACCUM : SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ACCUM: begin
                    if (cnt_q == WIN_LAST) begin
                        cnt_d   = '0;
                        state_d = LATCH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                LATCH: begin
                    latch = 1'b1;
                    if (cont_mode) begin
                        state_d = CLEAR;
                        clear_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A coincident ack is consumed by the new result, so it is not an overrun.
        if (latch) begin
            valid_d     = 1'b1;
            overrun_d   = overrun_q | (valid_q & ~res.result_ack);
            err_pwr_d   = pwr_new;
            ref_level_d = ref_new;
            err_count_d = cnt_new;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            err_pwr_q   <= '0;
            ref_level_q <= REF_INIT;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clear_q     <= clear_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            err_pwr_q   <= err_pwr_d;
            ref_level_q <= ref_level_d;
            err_count_q <= err_count_d;
        end
    end

`ifdef MER_ALARM_EN
    logic alarm_q, alarm_d;

    always_comb begin
        alarm_d = alarm_q;
        if (latch) begin
            alarm_d = (pwr_new > MER_THRESH);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign res.mer_alarm = alarm_q;
`else
    assign res.mer_alarm = 1'b0;
`endif

    assign clear_accum      = clear_q;
    assign busy             = busy_q;
    assign res.result_valid = valid_q;
    assign res.overrun      = overrun_q;
    assign res.err_pwr      = err_pwr_q;
    assign res.ref_level    = ref_level_q;
    assign res.err_count    = err_count_q;

endmodule

// File: tb/tb_mer_meas_ctrl.sv
// Scoreboard bench for mer_meas_ctrl with LOG2_WIN=4, SETTLE_SYMS=3.
module tb_mer_meas_ctrl;
    import mer_pkg::*;

    localparam int LW = 4;

    typedef struct {
        longint pwr;
        longint lvl;
        longint cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sym_clk_en = 1'b0;
    logic start = 1'b0;
    logic cont_mode = 1'b0;
    logic sym_error = 1'b0;
    logic signed [17:0] error = '0;
    logic signed [17:0] dec_var = '0;
    logic clear_accum;
    logic busy;

    int checks = 0;
    int errors = 0;
    int clr_pulses = 0;
    exp_t sb[$];

    mer_meas_ctrl_if #(.LOG2_WIN(LW)) res ();

    mer_meas_ctrl #(
        .LOG2_WIN    (LW),
        .SETTLE_SYMS (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sym_clk_en  (sym_clk_en),
        .start       (start),
        .cont_mode   (cont_mode),
        .error       (error),
        .dec_var     (dec_var),
        .sym_error   (sym_error),
        .clear_accum (clear_accum),
        .busy        (busy),
        .res         (res.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clear_accum) clr_pulses++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sym(input logic signed [17:0] e, input logic signed [17:0] d,
                       input logic se, input logic st, input logic ack);
        @(negedge clk);
        error = e; dec_var = d; sym_error = se; start = st; res.result_ack = ack;
        sym_clk_en = 1'b1;
        @(negedge clk);
        sym_clk_en = 1'b0; start = 1'b0; res.result_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        res.result_ack = 1'b1;
        @(negedge clk);
        res.result_ack = 1'b0;
    endtask

    task automatic gen(input int mode, input int i, output logic signed [17:0] e,
                       output logic signed [17:0] d, output logic se);
        se = 1'b0;
        case (mode)
            0: begin e = 18'sd4096;    d = 18'sd32768;  end
            1: begin e = -18'sd131072; d = 18'sd32768;  end
            2: begin e = 18'sd1000;    d = -18'sd131072; end
            3: begin
                e  = 18'($urandom);
                d  = 18'($urandom);
                se = (i == 1 || i == 3 || i == 7 || i == 8 || i == 15);
            end
            4: begin e = 18'sd16384;   d = 18'sd1000;   end
            5: begin e = 18'sd32768;   d = -18'sd5000;  end
            default: begin e = -18'sd2000; d = 18'sd77777; se = i[0]; end
        endcase
    endtask

    // Drives CLEAR/SETTLE with junk, then 16 ACCUM symbols, then the LATCH symbol.
    task automatic run_window(input int mode, input bit do_start, input bit ack_at_latch);
        longint ae = 0, aa = 0, ac = 0, le, ld;
        logic signed [17:0] e, d;
        logic se;
        exp_t x;
        if (do_start) begin
            sym(0, 0, 0, 1, 0);
            check("busy_after_start", busy, 1);
        end
        sym(-18'sd131072, -18'sd131072, 1, 1, 0);
        for (int s = 0; s < 3; s++) sym(-18'sd131072, -18'sd131072, 1, 1, 0);
        for (int i = 0; i < 16; i++) begin
            gen(mode, i, e, d, se);
            le = e; ld = d;
            ae += (le * le) >>> 17;
            aa += (ld < 0) ? -ld : ld;
            ac += se;
            sym(e, d, se, 0, 0);
        end
        x.pwr = ae >>> LW;  if (x.pwr > 262143) x.pwr = 262143;
        x.lvl = aa >>> LW;  if (x.lvl > 131071) x.lvl = 131071;
        x.cnt = ac;
        sb.push_back(x);
        sym(0, 0, 0, 0, ack_at_latch);
    endtask

    task automatic check_result(input string tag);
        exp_t x;
        check({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() == 0) return;
        x = sb.pop_front();
        check({tag, "_valid"}, res.result_valid, 1);
        check({tag, "_err_pwr"}, res.err_pwr, x.pwr);
        check({tag, "_ref_level"}, res.ref_level, x.lvl);
        check({tag, "_err_count"}, res.err_count, x.cnt);
`ifdef MER_ALARM_EN
        check({tag, "_alarm"}, res.mer_alarm, (x.pwr > 4096) ? 1 : 0);
`else
        check({tag, "_alarm"}, res.mer_alarm, 0);
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_clear"}, clear_accum, 0);
        check({tag, "_ref"}, res.ref_level, 32768);
        check({tag, "_pwr"}, res.err_pwr, 0);
        check({tag, "_cnt"}, res.err_count, 0);
        check({tag, "_valid"}, res.result_valid, 0);
        check({tag, "_overrun"}, res.overrun, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_alarm"}, res.mer_alarm, 0);
    endtask

    int c0;

    initial begin
        res.result_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("post_rst");

        ack_pulse();
        @(negedge clk);
        check("ack_idle_valid", res.result_valid, 0);

        // Basic window, then the saturation and error-count windows.
        c0 = clr_pulses;
        run_window(0, 1, 0);
        check_result("t1");
        check("t1_clr_pulses", clr_pulses - c0, 1);
        check("t1_busy", busy, 0);
        ack_pulse();
        @(negedge clk);
        check("t1_ack_valid", res.result_valid, 0);

        run_window(1, 1, 0);
        check_result("t2_maxerr");
        ack_pulse();
        run_window(2, 1, 0);
        check_result("t3_refsat");
        ack_pulse();
        run_window(3, 1, 0);
        check_result("t4_symerr");
        ack_pulse();

        // LATCH coincident with ack: new result wins, no overrun.
        cont_mode = 1'b1;
        run_window(0, 1, 0);
        check_result("t5a");
        cont_mode = 1'b0;
        run_window(2, 0, 1);
        check_result("t5b");
        check("t5_overrun", res.overrun, 0);
        ack_pulse();
        @(negedge clk);

        // Two continuous windows with no ack: overrun.
        c0 = clr_pulses;
        cont_mode = 1'b1;
        run_window(0, 1, 0);
        check_result("t6a");
        check("t6a_overrun", res.overrun, 0);
        cont_mode = 1'b0;
        run_window(4, 0, 0);
        check_result("t6b");
        check("t6b_overrun", res.overrun, 1);
        check("t6_clr_pulses", clr_pulses - c0, 2);
        check("t6_busy_idle", busy, 0);
        ack_pulse();
        @(negedge clk);
        check("t6_ack_valid", res.result_valid, 0);
        check("t6_ack_overrun", res.overrun, 1);

        // Reset in the middle of ACCUM discards the partial window.
        c0 = clr_pulses;
        sym(0, 0, 0, 1, 0);
        for (int s = 0; s < 4; s++) sym(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) sym(-18'sd131072, 18'sd100000, 1, 0, 0);
        #1 reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        check("midrst_clr_pulses", clr_pulses - c0, 1);
        c0 = clr_pulses;
        run_window(6, 1, 0);
        check_result("t7_after_rst");
        check("t7_clr_pulses", clr_pulses - c0, 1);
        ack_pulse();

        run_window(5, 1, 0);
        check_result("t8_high_err");
        ack_pulse();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
